// File: rtl/mac_seq_ctrl_if.sv
// Job/operand/result handshake bundle between a host and the mac8x8 sequencer.
// The master side requests jobs and streams operand pairs; the slave side is the sequencer.
interface mac_seq_ctrl_if #(
  parameter int DSIZE = 8,
  parameter int OSIZE = 16,
  parameter int LEN_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [DSIZE-1:0] in_x;
  logic [DSIZE-1:0] in_y;
  logic             res_valid;
  logic             res_ready;
  logic [OSIZE:0]   res_data;
  logic             res_ovf;

  modport master (
    output start, len, in_valid, in_x, in_y, res_ready,
    input  busy, in_ready, res_valid, res_data, res_ovf
  );

  modport slave (
    input  start, len, in_valid, in_x, in_y, res_ready,
    output busy, in_ready, res_valid, res_data, res_ovf
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for a single mac8x8 accumulator: clears it, streams operand
// pairs into it, waits out the pipeline, then holds the sum and overflow flag.
module mac_seq_ctrl #(
  parameter int DSIZE   = 8,
  parameter int OSIZE   = 16,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  mac_seq_ctrl_if.slave    bus,
  output logic [DSIZE-1:0] mac_x,
  output logic [DSIZE-1:0] mac_y,
  output logic             mac_rst,
  input  logic [OSIZE:0]   mac_dataout
);

  localparam int CNT_W = $clog2(MAC_LAT + 2);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [LEN_W-1:0] remain;
  logic [OSIZE:0]   prev;
  logic             hs;

  assign hs = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      remain        <= '0;
      prev          <= '0;
      bus.busy      <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_ovf   <= 1'b0;
      mac_x         <= '0;
      mac_y         <= '0;
      mac_rst       <= 1'b1;
    end else begin
      // NOTE: operands default to zero every cycle so idle cycles feed a zero
      // product; all state uses <= so every branch sees pre-edge values.
      mac_x <= '0;
      mac_y <= '0;

      unique case (state)
        IDLE: begin
          mac_rst <= 1'b0;
          if (bus.start) begin
            remain   <= bus.len;
            cnt      <= CNT_W'(MAC_LAT - 1);
            mac_rst  <= 1'b1;
            bus.busy <= 1'b1;
            state    <= CLEAR;
          end
        end

        CLEAR: begin
          prev        <= '0;
          bus.res_ovf <= 1'b0;
          if (cnt == '0) begin
            mac_rst      <= 1'b0;
            bus.in_ready <= (remain != '0);
            state        <= FEED;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        FEED: begin
          prev <= mac_dataout;
          if (mac_dataout < prev) bus.res_ovf <= 1'b1;
          if (hs) begin
            mac_x  <= bus.in_x;
            mac_y  <= bus.in_y;
            remain <= remain - LEN_W'(1);
          end
          // Drop ready on the same edge as the last handshake.
          if (remain == '0 || (hs && remain == LEN_W'(1))) begin
            bus.in_ready <= 1'b0;
            cnt          <= CNT_W'(MAC_LAT);
            state        <= DRAIN;
          end
        end

        DRAIN: begin
          prev <= mac_dataout;
          if (mac_dataout < prev) bus.res_ovf <= 1'b1;
          if (cnt == '0) begin
            bus.res_data  <= mac_dataout;
            bus.res_valid <= 1'b1;
            state         <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        DONE: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl with a behavioural two-stage mac8x8 beside it; the
// expected sum and overflow come from plain integer arithmetic over the pairs.
module tb_mac_seq_ctrl;
  localparam int DSIZE   = 8;
  localparam int OSIZE   = 16;
  localparam int LEN_W   = 8;
  localparam int MAC_LAT = 2;
  localparam longint MOD = 64'd1 << (OSIZE + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.DSIZE(DSIZE), .OSIZE(OSIZE), .LEN_W(LEN_W)) bus ();

  logic [DSIZE-1:0] mac_x, mac_y;
  logic             mac_rst;
  logic [OSIZE:0]   mac_dataout;
  logic [OSIZE:0]   mac_prod;

  mac_seq_ctrl #(.DSIZE(DSIZE), .OSIZE(OSIZE), .LEN_W(LEN_W), .MAC_LAT(MAC_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .mac_x      (mac_x),
    .mac_y      (mac_y),
    .mac_rst    (mac_rst),
    .mac_dataout(mac_dataout)
  );

  // mac8x8 stand-in: product register, then accumulator (two edges).
  always @(posedge clk) begin
    if (mac_rst) begin
      mac_prod    <= '0;
      mac_dataout <= '0;
    end else begin
      mac_prod    <= (OSIZE+1)'(mac_x) * (OSIZE+1)'(mac_y);
      mac_dataout <= mac_dataout + mac_prod;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [DSIZE-1:0] xs[$];
  logic [DSIZE-1:0] ys[$];

  function automatic void model(output logic [OSIZE:0] d, output logic o);
    longint s = 0;
    foreach (xs[i]) s += longint'(xs[i]) * longint'(ys[i]);
    d = (OSIZE+1)'(s % MOD);
    o = (s >= MOD);
  endfunction

  task automatic start_job(input int l);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = LEN_W'(l);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // gap_mode < 0: random 0..3 idle cycles between pairs, else fixed count.
  task automatic feed(input int nfeed, input int gap_mode);
    int idx = 0, gap = 0, budget = 0;
    logic took;
    while (idx < nfeed && budget < 1000) begin
      if (gap > 0) begin
        bus.in_valid = 1'b0;
        bus.in_x     = DSIZE'($urandom);
        bus.in_y     = DSIZE'($urandom);
        gap--;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_x     = xs[idx];
        bus.in_y     = ys[idx];
      end
      took = bus.in_valid && bus.in_ready;
      @(negedge clk);
      budget++;
      if (took) begin
        idx++;
        gap = (gap_mode < 0) ? int'($urandom_range(0, 3)) : gap_mode;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_x     = DSIZE'($urandom);
    bus.in_y     = DSIZE'($urandom);
    if (idx < nfeed) begin
      n_cmp++; n_bad++;
      $display("FAIL feed_timeout: accepted %0d, required %0d pairs", idx, nfeed);
    end else if (nfeed > 0 && nfeed == xs.size()) begin
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL in_ready_after_last: got %b, required 0", bus.in_ready);
      end
    end
  endtask

  task automatic check_result(input string name);
    logic [OSIZE:0] ed;
    logic eo;
    int budget = 0;
    model(ed, eo);
    while (bus.res_valid !== 1'b1 && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (bus.res_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_res_valid_timeout: got %b, required 1", name, bus.res_valid);
    end else begin
      n_cmp++;
      if (bus.res_data !== ed) begin
        n_bad++;
        $display("FAIL %s_res_data: got %0d, required %0d", name, bus.res_data, ed);
      end
      n_cmp++;
      if (bus.res_ovf !== eo) begin
        n_bad++;
        $display("FAIL %s_res_ovf: got %b, required %b", name, bus.res_ovf, eo);
      end
    end
  endtask

  task automatic release_res(input string name);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    n_cmp++;
    if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_release: res_valid=%b busy=%b, required 0 0", name, bus.res_valid, bus.busy);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0 ||
        bus.res_ovf !== 1'b0 || bus.res_data !== '0 || mac_x !== '0 ||
        mac_y !== '0 || mac_rst !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: busy=%b in_ready=%b res_valid=%b ovf=%b data=%0d mac_x=%0d mac_y=%0d mac_rst=%b, required 0 0 0 0 0 0 0 1",
               name, bus.busy, bus.in_ready, bus.res_valid, bus.res_ovf, bus.res_data,
               mac_x, mac_y, mac_rst);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (mac_rst !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: mac_rst=%b busy=%b, required 0 0", mac_rst, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    xs = '{8'd2, 8'd5, 8'd7, 8'd17};
    ys = '{8'd5, 8'd4, 8'd9, 8'd0};
    start_job(4);
    feed(4, 0);
    check_result("back_to_back");
    release_res("back_to_back");
  endtask

  task automatic test_bubbles();
    start_job(4);
    feed(4, 3);
    check_result("bubbles");
    release_res("bubbles");
  endtask

  task automatic test_overflow();
    xs = '{8'd255, 8'd255, 8'd255};
    ys = '{8'd255, 8'd255, 8'd255};
    start_job(3);
    feed(3, 0);
    check_result("overflow");
    release_res("overflow");
  endtask

  task automatic test_zero_len();
    xs.delete();
    ys.delete();
    start_job(0);
    check_result("zero_len");
    release_res("zero_len");
  endtask

  task automatic test_hold();
    logic [OSIZE:0] ed;
    logic eo;
    int bad = 0;
    xs = '{8'd9, 8'd200};
    ys = '{8'd3, 8'd77};
    model(ed, eo);
    start_job(2);
    feed(2, 1);
    check_result("hold");
    for (int i = 0; i < 10; i++) begin
      bus.start = (i == 3 || i == 4);
      bus.len   = 8'd5;
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_data !== ed || bus.busy !== 1'b1) bad++;
    end
    bus.start = 1'b0;
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL hold_stable: %0d cycles lost res_valid/res_data/busy, required 0", bad);
    end
    release_res("hold");
    @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL start_ignored_in_done: busy=%b, required 0", bus.busy);
    end
  endtask

  task automatic test_mid_reset();
    xs = '{8'd50, 8'd60, 8'd70, 8'd80};
    ys = '{8'd1, 8'd2, 8'd3, 8'd4};
    start_job(4);
    feed(2, 0);
    rst = 1'b1;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    xs = '{8'd11, 8'd1};
    ys = '{8'd11, 8'd100};
    start_job(2);
    feed(2, 0);
    check_result("after_reset");
    release_res("after_reset");
  endtask

  task automatic test_random();
    for (int j = 0; j < 6; j++) begin
      int l = int'($urandom_range(1, 12));
      xs.delete();
      ys.delete();
      for (int i = 0; i < l; i++) begin
        xs.push_back(DSIZE'($urandom));
        ys.push_back(DSIZE'($urandom));
      end
      start_job(l);
      feed(l, -1);
      check_result("random");
      repeat ($urandom_range(0, 4)) @(negedge clk);
      release_res("random");
    end
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.res_ready = 1'b0;
    test_reset();
    test_back_to_back();
    test_bubbles();
    test_overflow();
    test_zero_len();
    test_hold();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
